// File: rtl/serial_compare_ctrl_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM state values,
// result one-hot bit positions and the helper that builds the one-hot result.
package serial_cmp_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int RES_LT = 0;
    localparam int RES_EQ = 1;
    localparam int RES_GT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    typedef logic [2:0] res_t;

    // diff = {a_wins, b_wins} from the first differing bit; 2'b00 means no difference seen
    function automatic res_t res_onehot(input logic [1:0] diff);
        res_t r;
        r = '0;
        if (diff[1])      r[RES_GT] = 1'b1;
        else if (diff[0]) r[RES_LT] = 1'b1;
        else              r[RES_EQ] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_if.sv
// Start/result handshake bundle for serial_compare_ctrl. The requester drives
// operands and res_ready; the controller drives readiness, result and busy.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             res_valid;
    logic             res_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             busy;

    modport master (
        output start_valid, a_in, b_in, res_ready,
        input  start_ready, res_valid, gt, eq, lt, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, res_ready,
        output start_ready, res_valid, gt, eq, lt, busy
    );
endinterface

// File: rtl/serial_compare_ctrl_slice.sv
// Single-bit magnitude compare slice, time-shared across all operand bits.
module cmp_bit_slice (
    input  logic a,
    input  logic b,
    output logic g,
    output logic e,
    output logic l
);
    assign g = a & ~b;
    assign e = ~(a ^ b);
    assign l = ~a & b;
endmodule

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial unsigned comparator: one compare slice walks the operand
// bits one per cycle, and the gt/eq/lt result is held until it is consumed.
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_compare_ctrl_if.slave bus
);

    localparam int IDXW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [1:0]       diff_q, diff_d;
    logic             res_valid_q, res_valid_d;
    res_t             res_q, res_d;

    logic a_bit, b_bit;
    logic g_bit, e_bit, l_bit;
    logic first_hit;
    logic last_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    cmp_bit_slice u_slice (
        .a (a_bit),
        .b (b_bit),
        .g (g_bit),
        .e (e_bit),
        .l (l_bit)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        // Only the first mismatch decides the outcome; later bits are ignored.
        first_hit   = (state_q == ST_RUN) && (diff_q == 2'b00) && !e_bit;
        last_bit    = (idx_q == '0);

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    idx_d   = IDXW'(WIDTH - 1);
                    diff_d  = 2'b00;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (first_hit) diff_d = {g_bit, l_bit};
                if (((EARLY_EXIT != 0) && first_hit) || last_bit) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_d       = res_onehot(diff_d);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    res_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            diff_q      <= 2'b00;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.gt          = res_q[RES_GT];
    assign bus.eq          = res_q[RES_EQ];
    assign bus.lt          = res_q[RES_LT];

endmodule
